dma_read_ctrl: RTL and testbench
================================

DMA_READ_CTRL -- requirements
Module: dma_read_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 16, meaning the cap on in-flight read requests (1..64).
REQ-002 SHALL have parameter LEN_W, default 32, meaning the width of the line-count and index fields.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  meaning a one-cycle pulse that launches a transfer.
REQ-006 SHALL have port base_addr  input  64  meaning the cache-line address of the host buffer (bits [41:0] used), sampled at start.
REQ-007 SHALL have port num_lines  input  LEN_W  meaning the number of 64-byte lines to read, sampled at start.
REQ-008 SHALL have port c0_tx  output  t_if_ccip_c0_Tx  meaning the CCI-P read request channel.
REQ-009 SHALL have port c0_tx_alm_full  input  1  meaning CCI-P c0 almost-full backpressure.
REQ-010 SHALL have port c0_rx  input  t_if_ccip_c0_Rx  meaning the CCI-P read response channel.
REQ-011 SHALL have port rd_data  output  512  meaning the returned line data.
REQ-012 SHALL have port rd_idx  output  16  meaning the line index, modulo 2^16, of rd_data.
REQ-013 SHALL have port rd_valid  output  1  meaning rd_data/rd_idx valid for one cycle; there is no ready and the consumer must accept.
REQ-014 SHALL have ports busy  output  1  and done  output  1, where done is a one-cycle completion pulse.
REQ-015 SHALL have ports perf_cycles  output  32  and perf_stalls  output  32  meaning the performance counters defined in REQ-029.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE, with reset state IDLE.
REQ-017 SHALL, in IDLE, on start: latch base_addr and num_lines and clear the issued/received counters; go to DONE if num_lines==0, else to ISSUE.
REQ-018 SHALL, in ISSUE, assert c0_tx.valid for one cycle per request, issuing only when c0_tx_alm_full==0 and outstanding<MAX_OUTSTANDING.
REQ-019 SHALL build each request as a RDLINE_I with address = base + issued, cl_len = 1 line, and mdata = issued[15:0].
REQ-020 SHALL move ISSUE->DRAIN in the cycle the last request issues (issued reaches num_lines).
REQ-021 SHALL count a response only when c0_rx.rspValid is set, resp_type is eRSP_RDLINE, and state is ISSUE or DRAIN; all other responses are ignored.
REQ-022 SHALL register each counted response, driving rd_valid, rd_data = c0_rx.data and rd_idx = hdr.mdata exactly one cycle after rspValid; responses may arrive out of order.
REQ-023 SHALL keep outstanding = issued - received, unchanged when an issue and a response occur in the same cycle.
REQ-024 SHALL move DRAIN->DONE when received == num_lines; DONE pulses done for one cycle, then returns to IDLE.
REQ-025 SHALL drive busy = (state != IDLE), and SHALL ignore start while busy.
REQ-026 SHALL drive c0_tx.valid low in every state except ISSUE.

Reset
REQ-027 SHALL, on rst_n low (including mid-transfer): state=IDLE, all counters 0, c0_tx='0, rd_valid=0, rd_data=0, rd_idx=0, busy=0, done=0, perf_cycles=0, perf_stalls=0.
REQ-028 SHALL NOT count, after reset, any response belonging to a transfer that was aborted by reset.

Configuration
REQ-029 SHALL, with DMA_READ_CTRL_PERF_EN defined: clear both perf counters at start; increment perf_cycles every busy cycle; increment perf_stalls every ISSUE cycle blocked by c0_tx_alm_full or the outstanding cap; hold both counters after done; saturate both at all-ones.
REQ-030 SHALL, without DMA_READ_CTRL_PERF_EN, tie perf_cycles and perf_stalls to 0 and generate no counter logic.

Structure
REQ-031 SHALL place in a shared package: the state enum, the MAX_OUTSTANDING default, and the RDLINE request-header construction function.
REQ-032 SHALL keep the issue/outstanding credit counter as sub-module rd_credit_cnt; everything else is flat.

Verification
REQ-033 SHALL cover: base=0x1000, num_lines=4, no backpressure -> 4 requests with addresses 0x1000..0x1003 and mdata 0..3, 4 rd_valid pulses, done one cycle after the last rd_valid.
REQ-034 SHALL cover: num_lines=0 -> no c0_tx.valid, done pulse 2 cycles after start.
REQ-035 SHALL cover: num_lines=40, MAX_OUTSTANDING=16, responses withheld -> exactly 16 requests, then issue stalls; releasing responses resumes issue; 40 rd_valid pulses in total.
REQ-036 SHALL cover: c0_tx_alm_full held high for 10 cycles in ISSUE -> no requests during those cycles; perf_stalls=10 with DMA_READ_CTRL_PERF_EN, 0 without.
REQ-037 SHALL cover: responses returned in reverse order plus a start pulse mid-transfer -> rd_idx matches mdata and the second start is ignored.
REQ-038 SHALL cover: rst_n asserted with 5 requests outstanding, then a new 2-line transfer started -> the stale responses are ignored, exactly 2 rd_valid pulses, done asserted.

Source files
------------

// File: rtl/dma_read_ctrl_pkg.sv
// dma_read_ctrl_pkg: CCI-P c0 channel subset, FSM state codes and RDLINE header builder
// shared by the DMA read controller files.
package dma_read_ctrl_pkg;
   localparam int DEF_MAX_OUTSTANDING = 16;
   localparam logic [3:0] eREQ_RDLINE_I = 4'h2;
   localparam logic [3:0] eRSP_RDLINE = 4'h0;
   localparam logic [1:0] eCL_LEN_1 = 2'b00;
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_DRAIN = 2'd2, ST_DONE = 2'd3;
   typedef struct packed {
      logic [1:0]  vc_sel;
      logic [1:0]  rsvd1;
      logic [1:0]  cl_len;
      logic [3:0]  req_type;
      logic [5:0]  rsvd0;
      logic [41:0] address;
      logic [15:0] mdata;
   } t_ccip_c0_ReqMemHdr;
   typedef struct packed {
      t_ccip_c0_ReqMemHdr hdr;
      logic               valid;
   } t_if_ccip_c0_Tx;
   typedef struct packed {
      logic [1:0]  vc_used;
      logic        rsvd1;
      logic        hit_miss;
      logic [1:0]  rsvd0;
      logic [1:0]  cl_num;
      logic [3:0]  resp_type;
      logic [15:0] mdata;
   } t_ccip_c0_RspMemHdr;
   typedef struct packed {
      t_ccip_c0_RspMemHdr hdr;
      logic [511:0]       data;
      logic               rspValid;
      logic               mmioRdValid;
      logic               mmioWrValid;
   } t_if_ccip_c0_Rx;
   function automatic t_ccip_c0_ReqMemHdr rdline_hdr(input logic [41:0] addr, input logic [15:0] mdata);
      rdline_hdr = '0;
      rdline_hdr.cl_len = eCL_LEN_1;
      rdline_hdr.req_type = eREQ_RDLINE_I;
      rdline_hdr.address = addr;
      rdline_hdr.mdata = mdata;
   endfunction
endpackage

// File: rtl/dma_read_ctrl_if.sv
// dma_read_ctrl_if: CCI-P c0 request/response channel bundle; the controller is the master.
interface dma_read_ctrl_if;
   import dma_read_ctrl_pkg::*;
   t_if_ccip_c0_Tx c0_tx;
   logic           c0_tx_alm_full;
   t_if_ccip_c0_Rx c0_rx;
   modport master(output c0_tx, input c0_tx_alm_full, input c0_rx);
   modport slave(input c0_tx, output c0_tx_alm_full, output c0_rx);
endinterface

// File: rtl/dma_read_ctrl_credit.sv
// rd_credit_cnt: tracks in-flight read requests and grants issue while below the cap.
module rd_credit_cnt
   import dma_read_ctrl_pkg::*;
#(
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic issue_i,
   input  logic rsp_i,
   output logic can_issue_o
);
   logic [6:0] out_q, out_d;
   assign out_d = clr_i ? '0 : out_q + {6'd0, issue_i} - {6'd0, rsp_i};
   assign can_issue_o = out_q < 7'(MAX_OUTSTANDING);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) out_q <= '0;
      else out_q <= out_d;
endmodule

// File: rtl/dma_read_ctrl.sv
// dma_read_ctrl: streams num_lines cache lines from host memory over CCI-P c0.
// Optional perf counters enabled by defining DMA_READ_CTRL_PERF_EN.
module dma_read_ctrl
   import dma_read_ctrl_pkg::*;
#(
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
   parameter int LEN_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [63:0]      base_addr,
   input  logic [LEN_W-1:0] num_lines,
   dma_read_ctrl_if.master  bus,
   output logic [511:0]     rd_data,
   output logic [15:0]      rd_idx,
   output logic             rd_valid,
   output logic             busy,
   output logic             done,
   output logic [31:0]      perf_cycles,
   output logic [31:0]      perf_stalls
);
   state_t state_q, state_d;
   logic [41:0] base_q, base_d;
   logic [LEN_W-1:0] num_q, num_d, issued_q, issued_d, rcvd_q, rcvd_d;
   logic [511:0] rd_data_q;
   logic [15:0] rd_idx_q;
   logic rd_valid_q, done_q, launch, issue, rsp, can_issue, unused_bits;
   assign launch = state_q == ST_IDLE && start;
   assign issue = state_q == ST_ISSUE && !bus.c0_tx_alm_full && can_issue;
   assign rsp = bus.c0_rx.rspValid && bus.c0_rx.hdr.resp_type == eRSP_RDLINE &&
                (state_q == ST_ISSUE || state_q == ST_DRAIN);
   rd_credit_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_credit (
      .clk(clk), .rst_n(rst_n), .clr_i(launch), .issue_i(issue), .rsp_i(rsp), .can_issue_o(can_issue)
   );
   always_comb begin
      base_d = launch ? base_addr[41:0] : base_q;
      num_d = launch ? num_lines : num_q;
      issued_d = launch ? '0 : issued_q + LEN_W'(issue);
      rcvd_d = launch ? '0 : rcvd_q + LEN_W'(rsp);
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = start ? (num_lines == '0 ? ST_DONE : ST_ISSUE) : ST_IDLE;
         ST_ISSUE: state_d = issue && issued_d == num_q ? ST_DRAIN : ST_ISSUE;
         ST_DRAIN: state_d = rcvd_d == num_q ? ST_DONE : ST_DRAIN;
         default:  state_d = ST_IDLE;
      endcase
   end
   // Request is combinational so valid never leaks outside ISSUE.
   assign bus.c0_tx = issue ? '{hdr: rdline_hdr(base_q + 42'(issued_q), issued_q[15:0]), valid: 1'b1} : '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= ST_IDLE;
         base_q <= '0;
         num_q <= '0;
         issued_q <= '0;
         rcvd_q <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q <= '0;
         rd_idx_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q <= base_d;
         num_q <= num_d;
         issued_q <= issued_d;
         rcvd_q <= rcvd_d;
         rd_valid_q <= rsp;
         rd_data_q <= rsp ? bus.c0_rx.data : rd_data_q;
         rd_idx_q <= rsp ? bus.c0_rx.hdr.mdata : rd_idx_q;
         done_q <= state_q == ST_DONE;
      end
   assign rd_valid = rd_valid_q;
   assign rd_data = rd_data_q;
   assign rd_idx = rd_idx_q;
   assign busy = state_q != ST_IDLE;
   assign done = done_q;
   assign unused_bits = ^{base_addr[63:42], bus.c0_rx.mmioRdValid, bus.c0_rx.mmioWrValid,
                          bus.c0_rx.hdr.vc_used, bus.c0_rx.hdr.rsvd1, bus.c0_rx.hdr.hit_miss,
                          bus.c0_rx.hdr.rsvd0, bus.c0_rx.hdr.cl_num};
`ifdef DMA_READ_CTRL_PERF_EN
   logic [31:0] cyc_q, cyc_d, stall_q, stall_d;
   always_comb begin
      cyc_d = launch ? '0 : (busy && cyc_q != '1) ? cyc_q + 32'd1 : cyc_q;
      stall_d = launch ? '0 : (state_q == ST_ISSUE && !issue && stall_q != '1) ? stall_q + 32'd1 : stall_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cyc_q <= '0;
         stall_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         stall_q <= stall_d;
      end
   assign perf_cycles = cyc_q;
   assign perf_stalls = stall_q;
`else
   assign perf_cycles = '0;
   assign perf_stalls = '0;
`endif
endmodule

// File: tb/tb_dma_read_ctrl.sv
// tb_dma_read_ctrl: directed bench for dma_read_ctrl with hand-computed expectations.
module tb_dma_read_ctrl;
   import dma_read_ctrl_pkg::*;
`ifdef DMA_READ_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [63:0] base_addr = '0;
   logic [31:0] num_lines = '0;
   logic [511:0] rd_data;
   logic [15:0] rd_idx;
   logic rd_valid, busy, done;
   logic [31:0] perf_cycles, perf_stalls;
   int n_chk = 0, n_err = 0, n_done = 0, cyc = 0, done_cyc = 0, last_rdv = 0, s_cyc = 0;
   logic [63:0] req_addr[$];
   int req_md[$], pend[$], rdv_idx[$];
   dma_read_ctrl_if bus();
   dma_read_ctrl #(.MAX_OUTSTANDING(16), .LEN_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_lines(num_lines),
      .bus(bus), .rd_data(rd_data), .rd_idx(rd_idx), .rd_valid(rd_valid), .busy(busy), .done(done),
      .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [511:0] dat(input logic [15:0] i);
      return {8{48'hC0DE_0000_0000, i}};
   endfunction
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (bus.c0_tx.valid) begin
         req_addr.push_back(64'(bus.c0_tx.hdr.address));
         req_md.push_back(int'(bus.c0_tx.hdr.mdata));
         pend.push_back(int'(bus.c0_tx.hdr.mdata));
         check("req_hdr", 64'({bus.c0_tx.hdr.cl_len, bus.c0_tx.hdr.req_type}), 64'({eCL_LEN_1, eREQ_RDLINE_I}));
         check("req_busy", 64'(busy), 64'd1);
      end
      if (rd_valid) begin
         rdv_idx.push_back(int'(rd_idx));
         last_rdv = cyc;
         check("rd_data", 64'(rd_data == dat(rd_idx)), 64'd1);
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
   end
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic go(input logic [63:0] b, input int n);
      base_addr = b;
      num_lines = 32'(n);
      start = 1'b1;
      s_cyc = cyc;
      tick();
      start = 1'b0;
   endtask
   task automatic rsp(input int idx, input logic [3:0] t = eRSP_RDLINE);
      bus.c0_rx.hdr.mdata = 16'(idx);
      bus.c0_rx.hdr.resp_type = t;
      bus.c0_rx.data = dat(16'(idx));
      bus.c0_rx.rspValid = 1'b1;
      tick();
      bus.c0_rx.rspValid = 1'b0;
   endtask
   // Answer pending requests in order until done is seen or the budget runs out.
   task automatic serve(input int budget);
      int d0, g;
      d0 = n_done;
      g = 0;
      while (n_done == d0 && g < budget) begin
         if (pend.size() > 0) rsp(pend.pop_front());
         else tick();
         g++;
      end
      check("done_seen", 64'(n_done - d0), 64'd1);
   endtask
   task automatic check_reset(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_rdv"}, 64'(rd_valid), 64'd0);
      check({tag, "_rdata"}, 64'(rd_data != '0), 64'd0);
      check({tag, "_ridx"}, 64'(rd_idx), 64'd0);
      check({tag, "_c0tx"}, 64'(bus.c0_tx != '0), 64'd0);
      check({tag, "_perf"}, {perf_cycles, perf_stalls}, 64'd0);
   endtask
   initial begin
      int a0, r0, d0, sum;
      bus.c0_rx = '0;
      bus.c0_tx_alm_full = 1'b0;
      tick(3);
      check_reset("rst");
      rst_n = 1'b1;
      tick(2);
      // 4 lines, no backpressure
      a0 = req_addr.size();
      r0 = rdv_idx.size();
      go(64'h1000, 4);
      tick(4);
      check("t1_nreq", 64'(req_addr.size() - a0), 64'd4);
      for (int i = 0; i < 4; i++) begin
         check("t1_addr", req_addr[a0 + i], 64'h1000 + 64'(i));
         check("t1_mdata", 64'(req_md[a0 + i]), 64'(i));
      end
      pend.delete();
      for (int i = 0; i < 4; i++) rsp(i);
      tick(3);
      check("t1_nrdv", 64'(rdv_idx.size() - r0), 64'd4);
      for (int i = 0; i < 4; i++) check("t1_idx", 64'(rdv_idx[r0 + i]), 64'(i));
      check("t1_done_lat", 64'(done_cyc - last_rdv), 64'd1);
      check("t1_busy", 64'(busy), 64'd0);
      check("t1_pcyc", 64'(perf_cycles), PERF ? 64'd9 : 64'd0);
      check("t1_pstall", 64'(perf_stalls), 64'd0);
      // zero-length transfer
      a0 = req_addr.size();
      go(64'h2000, 0);
      tick(4);
      check("t2_nreq", 64'(req_addr.size() - a0), 64'd0);
      check("t2_done_lat", 64'(done_cyc - s_cyc), 64'd2);
      check("t2_pcyc", 64'(perf_cycles), PERF ? 64'd1 : 64'd0);
      // outstanding cap with responses withheld
      a0 = req_addr.size();
      r0 = rdv_idx.size();
      go(64'h10000, 40);
      tick(30);
      check("t3_capped", 64'(req_addr.size() - a0), 64'd16);
      check("t3_valid_low", 64'(bus.c0_tx.valid), 64'd0);
      check("t3_busy", 64'(busy), 64'd1);
      check("t3_pstall", 64'(perf_stalls), PERF ? 64'd14 : 64'd0);
      serve(400);
      check("t3_nreq", 64'(req_addr.size() - a0), 64'd40);
      check("t3_nrdv", 64'(rdv_idx.size() - r0), 64'd40);
      sum = 0;
      for (int i = r0; i < rdv_idx.size(); i++) sum += rdv_idx[i];
      check("t3_idx_sum", 64'(sum), 64'd780);
      check("t3_last_addr", req_addr[a0 + 39], 64'h10000 + 64'd39);
      // almost-full held 10 ISSUE cycles
      a0 = req_addr.size();
      bus.c0_tx_alm_full = 1'b1;
      go(64'h2000, 2);
      tick(10);
      check("t4_blocked", 64'(req_addr.size() - a0), 64'd0);
      bus.c0_tx_alm_full = 1'b0;
      serve(50);
      check("t4_nreq", 64'(req_addr.size() - a0), 64'd2);
      check("t4_pstall", 64'(perf_stalls), PERF ? 64'd10 : 64'd0);
      check("t4_pcyc", 64'(perf_cycles), PERF ? 64'd14 : 64'd0);
      // reverse-order responses, stray start, non-RDLINE response
      a0 = req_addr.size();
      r0 = rdv_idx.size();
      d0 = n_done;
      go(64'h3000, 4);
      tick(4);
      base_addr = 64'h9000;
      num_lines = 32'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      pend.delete();
      rsp(3);
      rsp(2);
      rsp(0, 4'h1);
      rsp(1);
      rsp(0);
      tick(3);
      check("t5_nrdv", 64'(rdv_idx.size() - r0), 64'd4);
      for (int i = 0; i < 4; i++) check("t5_rev_idx", 64'(rdv_idx[r0 + i]), 64'(3 - i));
      check("t5_nreq", 64'(req_addr.size() - a0), 64'd4);
      check("t5_addr0", req_addr[a0], 64'h3000);
      check("t5_ndone", 64'(n_done - d0), 64'd1);
      tick(3);
      check("t5_no_restart", 64'(busy), 64'd0);
      // reset with 5 outstanding, stale responses, fresh transfer
      a0 = req_addr.size();
      go(64'h4000, 8);
      tick(5);
      bus.c0_tx_alm_full = 1'b1;
      tick();
      check("t6_outstanding", 64'(req_addr.size() - a0), 64'd5);
      rst_n = 1'b0;
      #1;
      check_reset("t6_rst");
      tick();
      rst_n = 1'b1;
      bus.c0_tx_alm_full = 1'b0;
      pend.delete();
      r0 = rdv_idx.size();
      for (int i = 0; i < 5; i++) rsp(i);
      tick();
      check("t6_stale", 64'(rdv_idx.size() - r0), 64'd0);
      a0 = req_addr.size();
      go(64'h5000, 2);
      serve(50);
      tick(2);
      check("t6_nrdv", 64'(rdv_idx.size() - r0), 64'd2);
      check("t6_nreq", 64'(req_addr.size() - a0), 64'd2);
      check("t6_addr0", req_addr[a0], 64'h5000);
      check("t6_addr1", req_addr[a0 + 1], 64'h5001);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
